// File: rtl/quadratic_eq_arbiter.sv
// quadratic_eq_arbiter
//
// Round-robin arbiter that shares a single quadratic_eq evaluator
// (a*x^2 + b*x + c) among N_REQ requesters. The winner's operands are
// latched onto ev_*, a one-cycle ev_inicio pulse starts the evaluator, and
// the 16-bit result comes back with a one-cycle done pulse to the winner.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req[N_REQ]            request levels, held by requester i until done[i]
//   req_x/a/b/c           packed operands; slice i = [W*i +: W]
//   gnt[N_REQ]            one-hot grant, ISSUE through RESP
//   done[N_REQ]           one-hot completion pulse (RESP)
//   resultado[16]         result of the last completed operation
//   err                   timeout flag, pulses with done
//   busy                  high whenever the FSM is not IDLE
//   ev_x/a/b/c, ev_inicio operands and start pulse to the evaluator
//   ev_pronto, ev_resultado  evaluator ready level and result
//
// Optional build macro QEA_TIMEOUT_EN adds a watchdog of TIMEOUT_CYC cycles
// on WAIT_LOW + WAIT_HIGH; a timeout completes with resultado=16'hFFFF and
// err=1. Without it err is tied low and the FSM waits indefinitely.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | arbitrate; latch winner index and operands
// ISSUE     | ev_inicio pulse, grant asserted
// WAIT_LOW  | wait for ev_pronto low (start accepted; stale high ignored)
// WAIT_HIGH | wait for ev_pronto high, capture ev_resultado
// RESP      | done pulse to winner, pointer moves to winner

module quadratic_eq_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [8*N_REQ-1:0]    req_x,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    input  logic [16*N_REQ-1:0]   req_c,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [15:0]           resultado,
    output logic                  err,
    output logic                  busy,
    output logic [7:0]            ev_x,
    output logic [15:0]           ev_a,
    output logic [15:0]           ev_b,
    output logic [15:0]           ev_c,
    output logic                  ev_inicio,
    input  logic                  ev_pronto,
    input  logic [15:0]           ev_resultado
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_LOW  = 3'd2;
    localparam logic [2:0] WAIT_HIGH = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] idx;
    logic [PW-1:0] ptr;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] cand;
    logic          pick_vld;
    logic          timeout_hit;
    logic          waiting;

    logic [7:0]  x_slice [N_REQ];
    logic [15:0] a_slice [N_REQ];
    logic [15:0] b_slice [N_REQ];
    logic [15:0] c_slice [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign x_slice[g] = req_x[8*g +: 8];
        assign a_slice[g] = req_a[16*g +: 16];
        assign b_slice[g] = req_b[16*g +: 16];
        assign c_slice[g] = req_c[16*g +: 16];
    end

    // Rotating priority: first set request after ptr, wrapping modulo N_REQ.
    // ptr itself is visited last, so the most recently served requester
    // has lowest priority.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign waiting = (state == WAIT_LOW) || (state == WAIT_HIGH);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            ptr       <= PW'(N_REQ - 1);
            ev_x      <= '0;
            ev_a      <= '0;
            ev_b      <= '0;
            ev_c      <= '0;
            resultado <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        idx   <= pick_idx;
                        ev_x  <= x_slice[pick_idx];
                        ev_a  <= a_slice[pick_idx];
                        ev_b  <= b_slice[pick_idx];
                        ev_c  <= c_slice[pick_idx];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (timeout_hit) begin
                        resultado <= 16'hFFFF;
                        state     <= RESP;
                    end else if (!ev_pronto) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // A real completion in the same cycle wins over timeout.
                    if (ev_pronto) begin
                        resultado <= ev_resultado;
                        state     <= RESP;
                    end else if (timeout_hit) begin
                        resultado <= 16'hFFFF;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= idx;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign ev_inicio = (state == ISSUE);
    assign gnt       = busy ? (N_REQ'(1) << idx) : '0;
    assign done      = (state == RESP) ? (N_REQ'(1) << idx) : '0;

`ifdef QEA_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    // Down-counter loaded when the operation is issued; reaching zero while
    // still waiting marks the TIMEOUT_CYC-th wait cycle.
    logic [WDW-1:0] wd;
    logic           to_flag;

    assign timeout_hit = waiting && (wd == '0) && !((state == WAIT_HIGH) && ev_pronto);

    always_ff @(posedge clock) begin
        if (reset) begin
            wd      <= '0;
            to_flag <= 1'b0;
        end else if (state == ISSUE) begin
            wd      <= WDW'(TIMEOUT_CYC - 1);
            to_flag <= 1'b0;
        end else if (waiting) begin
            if (wd != '0) begin
                wd <= wd - 1'b1;
            end
            if (timeout_hit) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign err = (state == RESP) && to_flag;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_quadratic_eq_arbiter.sv
module tb_quadratic_eq_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_x;
    logic [63:0] req_a, req_b, req_c;
    logic [3:0]  gnt, done;
    logic [15:0] resultado;
    logic        err, busy;
    logic [7:0]  ev_x;
    logic [15:0] ev_a, ev_b, ev_c;
    logic        ev_inicio;
    logic        ev_pronto;
    logic [15:0] ev_resultado;

    always #5 clock = ~clock;

    quadratic_eq_arbiter #(.N_REQ(4), .TIMEOUT_CYC(10)) dut (
        .clock(clock), .reset(reset), .req(req),
        .req_x(req_x), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .gnt(gnt), .done(done), .resultado(resultado), .err(err), .busy(busy),
        .ev_x(ev_x), .ev_a(ev_a), .ev_b(ev_b), .ev_c(ev_c),
        .ev_inicio(ev_inicio), .ev_pronto(ev_pronto), .ev_resultado(ev_resultado)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] quad(input logic [7:0] x, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] c);
        longint r;
        r = longint'(a) * longint'(x) * longint'(x) + longint'(b) * longint'(x) + longint'(c);
        return r[15:0];
    endfunction

    // Behavioural evaluator: pronto idles high, drops em_drop cycles after
    // accepting a start, rises em_rise cycles later with the result.
    bit          em_busy, em_seen, em_never, em_force, em_rand, em_raised;
    int          em_cnt, em_drop, em_rise, n_inicio;
    logic [15:0] em_val, em_res;

    task automatic eval_reset();
        em_busy = 0; em_seen = 0; em_cnt = 0;
        ev_pronto = 1'b1; ev_resultado = 16'h0;
    endtask

    task automatic eval_step();
        if (em_seen) begin
            em_seen = 0; em_busy = 1; em_cnt = 0;
            em_res = em_force ? em_val : quad(ev_x, ev_a, ev_b, ev_c);
            if (em_rand) begin
                em_drop = $urandom_range(1, 3);
                em_rise = $urandom_range(1, 6);
            end
        end else if (em_busy) begin
            em_cnt++;
            if (em_cnt == em_drop) ev_pronto = 1'b0;
            if (!em_never && em_cnt == em_drop + em_rise) begin
                ev_pronto = 1'b1; ev_resultado = em_res; em_busy = 0; em_raised = 1;
            end
        end
    endtask

    task automatic sample();
        if (ev_inicio === 1'b1) begin
            em_seen = 1; n_inicio++;
        end
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("done_within_gnt", 32'(done & ~gnt), 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        eval_step();
        @(negedge clock);
        sample();
    endtask

    task automatic wait_done(input int budget, output logic [3:0] d, output int steps);
        d = '0; steps = budget;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done !== 4'b0) begin
                d = done; steps = i + 1;
                return;
            end
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] x, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c);
        req_x[8*i +: 8] = x; req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b; req_c[16*i +: 16] = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        eval_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_wait_high();
        for (int i = 0; i < 20; i++) begin
            step();
            if (ev_pronto == 1'b0) break;
        end
        step();
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  x;
        logic [15:0] a, b, c;
        logic [3:0]  exp_done;
        logic [15:0] exp_res;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  d;
        logic [3:0]  e;
        int          steps, n0, extra;

        tbl[0] = '{4'b0001, 8'd4,   16'd1,     16'd2,  16'd3,      4'b0001, 16'h001B};
        tbl[1] = '{4'b0100, 8'd0,   16'd5,     16'd7,  16'h1234,   4'b0100, 16'h1234};
        tbl[2] = '{4'b1000, 8'd255, 16'd1,     16'd0,  16'd0,      4'b1000, 16'hFE01};
        tbl[3] = '{4'b0010, 8'd255, 16'd2,     16'd0,  16'd0,      4'b0010, 16'hFC02};
        tbl[4] = '{4'b0001, 8'd16,  16'h0100,  16'd0,  16'd1,      4'b0001, 16'h0001};
        tbl[5] = '{4'b1000, 8'd3,   16'hFFFF,  16'd0,  16'd0,      4'b1000, 16'hFFF7};
        tbl[6] = '{4'b0100, 8'd1,   16'd1,     16'd1,  16'd1,      4'b0100, 16'h0003};
        tbl[7] = '{4'b1011, 8'd2,   16'd0,     16'd3,  16'd1,      4'b1000, 16'h0007};
        tbl[8] = '{4'b0011, 8'd1,   16'd0,     16'd0,  16'd9,      4'b0001, 16'h0009};
        tbl[9] = '{4'b1100, 8'd5,   16'd0,     16'd10, 16'd0,      4'b0100, 16'h0032};

        req = '0; req_x = '0; req_a = '0; req_b = '0; req_c = '0;
        em_never = 0; em_force = 0; em_rand = 0; em_raised = 0;
        em_drop = 1; em_rise = 3; em_val = '0; em_res = '0; n_inicio = 0;
        do_reset();

        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_inicio", 32'(ev_inicio), 32'd0);
        chk("rst_resultado", 32'(resultado), 32'd0);
        chk("rst_ev_x", 32'(ev_x), 32'd0);
        chk("rst_ev_a", 32'(ev_a), 32'd0);

        // Table: single and multi-request arbitrations with known pointer history
        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < 4; r++) set_ops(r, tbl[i].x, tbl[i].a, tbl[i].b, tbl[i].c);
            req = tbl[i].req;
            n0 = n_inicio;
            wait_done(30, d, steps);
            chk($sformatf("tbl%0d_done", i), 32'(d), 32'(tbl[i].exp_done));
            chk($sformatf("tbl%0d_res", i), 32'(resultado), 32'(tbl[i].exp_res));
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].exp_done));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
            chk($sformatf("tbl%0d_latency", i), 32'(steps), 32'd7);
            req = '0;
            step();
            chk($sformatf("tbl%0d_inicio_cnt", i), 32'(n_inicio - n0), 32'd1);
            chk($sformatf("tbl%0d_idle_busy", i), 32'(busy), 32'd0);
        end

        // Contention: all requesters held, service order 0,1,2,3,0
        do_reset();
        for (int r = 0; r < 4; r++) set_ops(r, 8'(r + 1), 16'd0, 16'd1, 16'd0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(30, d, steps);
            e = 4'b0001 << (k % 4);
            chk($sformatf("rr%0d_done", k), 32'(d), 32'(e));
            chk($sformatf("rr%0d_res", k), 32'(resultado), 32'((k % 4) + 1));
        end
        req = '0;
        step();
        step();

        // Stale pronto: evaluator high while idle, late drop and late rise
        em_force = 1; em_val = 16'h1234; em_drop = 2; em_rise = 5; em_raised = 0;
        set_ops(0, 8'd9, 16'd9, 16'd9, 16'd9);
        n0 = n_inicio;
        req = 4'b0001;
        wait_done(40, d, steps);
        chk("stale_done", 32'(d), 32'b0001);
        chk("stale_no_early", 32'(em_raised), 32'd1);
        chk("stale_res", 32'(resultado), 32'h1234);
        req = '0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done !== 4'b0) extra++;
        end
        chk("stale_single_done", 32'(extra), 32'd0);
        chk("stale_inicio_cnt", 32'(n_inicio - n0), 32'd1);
        em_force = 0; em_drop = 1; em_rise = 5;

        // Granted requester drops req during WAIT_HIGH
        set_ops(2, 8'd3, 16'd2, 16'd1, 16'd0);
        req = 4'b0100;
        wait_wait_high();
        req[2] = 1'b0;
        wait_done(30, d, steps);
        chk("drop_done", 32'(d), 32'b0100);
        chk("drop_res", 32'(resultado), 32'd21);
        step();

        // Reset during WAIT_HIGH
        set_ops(3, 8'd7, 16'd5, 16'd5, 16'd5);
        set_ops(0, 8'd2, 16'd1, 16'd0, 16'd0);
        req = 4'b1000;
        wait_wait_high();
        reset = 1'b1;
        eval_reset();
        req = 4'b1001;
        step();
        chk("mrst_gnt", 32'(gnt), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_inicio", 32'(ev_inicio), 32'd0);
        chk("mrst_resultado", 32'(resultado), 32'd0);
        chk("mrst_ev_x", 32'(ev_x), 32'd0);
        chk("mrst_ev_abc", 32'(ev_a | ev_b | ev_c), 32'd0);
        reset = 1'b0;
        wait_done(30, d, steps);
        chk("mrst_next_grant", 32'(d), 32'b0001);
        chk("mrst_next_res", 32'(resultado), 32'd4);
        req = '0;
        step();

        // Evaluator that never completes
        em_never = 1; em_drop = 1;
        set_ops(1, 8'd1, 16'd1, 16'd1, 16'd1);
        req = 4'b0010;
`ifdef QEA_TIMEOUT_EN
        wait_done(40, d, steps);
        chk("to_done", 32'(d), 32'b0010);
        chk("to_err", 32'(err), 32'd1);
        chk("to_res", 32'(resultado), 32'hFFFF);
        chk("to_latency", 32'(steps), 32'd12);
        req = '0;
        step();
        chk("to_err_clears", 32'(err), 32'd0);
`else
        begin
            int nb, ne, nd;
            nb = 0; ne = 0; nd = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (busy !== 1'b1) nb++;
                if (err !== 1'b0) ne++;
                if (done !== 4'b0) nd++;
            end
            chk("hang_busy_low_cycles", 32'(nb), 32'd0);
            chk("hang_err_cycles", 32'(ne), 32'd0);
            chk("hang_done_cycles", 32'(nd), 32'd0);
        end
        req = '0;
`endif
        em_never = 0;
        do_reset();

        // Randomized traffic against a rotating-priority reference
        begin
            int          last, exp_w, pend_age, n_served;
            bit          pending, just_done;
            logic [15:0] exp_r;
            last = 3; pending = 0; pend_age = 0; n_served = 0; exp_w = 0; exp_r = '0;
            em_rand = 1;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                step();
                just_done = 0;
                if (done !== 4'b0) begin
                    if (!pending) begin
                        chk("rand_unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = 4'b0001 << exp_w;
                        chk("rand_done", 32'(done), 32'(e));
                        chk("rand_res", 32'(resultado), 32'(exp_r));
                        chk("rand_err", 32'(err), 32'd0);
                        last = exp_w;
                        req[exp_w] = 1'b0;
                        pending = 0;
                        just_done = 1;
                        n_served++;
                    end
                end else if (pending) begin
                    pend_age++;
                    if (pend_age > 60) begin
                        chk("rand_stuck", 32'(pend_age), 32'd0);
                        break;
                    end
                end
                if (cyc < 1300) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!req[i] && $urandom_range(0, 3) == 0) begin
                            set_ops(i, 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                            req[i] = 1'b1;
                        end
                    end
                end
                if (!pending && !just_done) begin
                    chk("rand_idle_busy", 32'(busy), 32'd0);
                    if (req != 4'b0) begin
                        for (int k = 1; k <= 4; k++) begin
                            if (req[(last + k) % 4]) begin
                                exp_w = (last + k) % 4;
                                break;
                            end
                        end
                        exp_r = quad(req_x[8*exp_w +: 8], req_a[16*exp_w +: 16],
                                     req_b[16*exp_w +: 16], req_c[16*exp_w +: 16]);
                        pending = 1;
                        pend_age = 0;
                    end
                end
            end
            chk("rand_drained", 32'(pending), 32'd0);
            chk("rand_enough_traffic", 32'(n_served > 20), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
